// File: rtl/gpio_pkg.sv
// gpio_pkg: shared constants and types for the GPIO pin-mux controller.
//   - pin-cell mode codes
//   - register map addresses
//   - peripheral requester IDs, their claim priority and the mode code each one owns
//   - claim arbiter FSM state encoding
package gpio_pkg;

  localparam int MAX_PINS = 8;
  localparam int BUS_AW   = 4;
  localparam int BUS_DW   = 8;
  localparam int NUM_REQ  = 4;

  localparam logic [3:0] MODE_INPUT    = 4'b0000;
  localparam logic [3:0] MODE_GPIO_OUT = 4'b0001;
  localparam logic [3:0] MODE_PWM      = 4'b0010;
  localparam logic [3:0] MODE_TONE     = 4'b0011;
  localparam logic [3:0] MODE_UART_TX  = 4'b0100;
  localparam logic [3:0] MODE_UART_RX  = 4'b0101;

  localparam logic [3:0] ADDR_DATA     = 4'h0;
  localparam logic [3:0] ADDR_PIN      = 4'h1;
  localparam logic [3:0] ADDR_EIMSK    = 4'h2;
  localparam logic [3:0] ADDR_EIFR     = 4'h3;
  localparam logic [3:0] ADDR_EICRA_LO = 4'h4;
  localparam logic [3:0] ADDR_EICRA_HI = 4'h5;
  localparam logic [3:0] ADDR_MSEL     = 4'h6;
  localparam logic [3:0] ADDR_MODE     = 4'h7;
  localparam logic [3:0] ADDR_OWN      = 4'h8;

  typedef logic [1:0] req_id_t;
  localparam req_id_t REQ_PWM     = 2'd0;
  localparam req_id_t REQ_TONE    = 2'd1;
  localparam req_id_t REQ_UART_TX = 2'd2;
  localparam req_id_t REQ_UART_RX = 2'd3;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_CHECK,
    ARB_RESP
  } arb_state_t;

  // Fixed priority: UART RX > UART TX > PWM > tone.
  // Only meaningful when at least one request bit is set.
  function automatic req_id_t pick_requester(input logic [NUM_REQ-1:0] req);
    if (req[REQ_UART_RX])      return REQ_UART_RX;
    else if (req[REQ_UART_TX]) return REQ_UART_TX;
    else if (req[REQ_PWM])     return REQ_PWM;
    else                       return REQ_TONE;
  endfunction

  function automatic logic [3:0] requester_code(input req_id_t id);
    case (id)
      REQ_PWM:     return MODE_PWM;
      REQ_TONE:    return MODE_TONE;
      REQ_UART_TX: return MODE_UART_TX;
      default:     return MODE_UART_RX;
    endcase
  endfunction

endpackage

// File: rtl/gpio_pinmux_ctrl_if.sv
// gpio_pinmux_ctrl_if: CPU peripheral bus between the CPU (master) and the
// pin-mux controller (slave).
//   bus_we/bus_re : single-cycle write/read strobes
//   bus_addr      : register address
//   bus_wdata     : write data
//   bus_rdata     : registered read data, qualified by the bus_rvalid pulse
interface gpio_pinmux_ctrl_if;
  import gpio_pkg::*;

  logic              bus_we;
  logic              bus_re;
  logic [BUS_AW-1:0] bus_addr;
  logic [BUS_DW-1:0] bus_wdata;
  logic [BUS_DW-1:0] bus_rdata;
  logic              bus_rvalid;

  modport master (
    output bus_we, bus_re, bus_addr, bus_wdata,
    input  bus_rdata, bus_rvalid
  );

  modport slave (
    input  bus_we, bus_re, bus_addr, bus_wdata,
    output bus_rdata, bus_rvalid
  );

endinterface

// File: rtl/gpio_claim_arb.sv
// gpio_claim_arb: arbitrates pin claims from PWM, tone, UART TX and UART RX.
// Holds the per-pin ownership table and emits a one-cycle commit telling the
// register file which pin gets which mode code.
//   clk, rst          : clock, async active-high reset
//   claim_req/rel/pin : per-requester request, release flag, 3-bit pin index
//   claim_ack/ok      : one-cycle done pulse per requester plus outcome
//   own               : one bit per currently claimed pin
//   commit_*          : pin/code update, valid for exactly the CHECK cycle
module gpio_claim_arb
  import gpio_pkg::*;
#(
  parameter int NPINS = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     claim_req,
  input  logic [NUM_REQ-1:0]     claim_rel,
  input  logic [3*NUM_REQ-1:0]   claim_pin,
  output logic [NUM_REQ-1:0]     claim_ack,
  output logic                   claim_ok,
  output logic [MAX_PINS-1:0]    own,
  output logic                   commit_valid,
  output logic [2:0]             commit_pin,
  output logic [3:0]             commit_code
);

  arb_state_t          state;
  req_id_t             req_id;
  logic                req_rel;
  logic [2:0]          req_pin;
  logic [MAX_PINS-1:0] own_q;
  req_id_t             owner [MAX_PINS];

  req_id_t    sel_id;
  logic [2:0] sel_pin;
  logic       in_range;
  logic       is_owner;
  logic       no_change;
  logic       grant;

  always_comb begin
    sel_id = pick_requester(claim_req);
    case (sel_id)
      REQ_PWM:     sel_pin = claim_pin[2:0];
      REQ_TONE:    sel_pin = claim_pin[5:3];
      REQ_UART_TX: sel_pin = claim_pin[8:6];
      default:     sel_pin = claim_pin[11:9];
    endcase

    in_range = ({1'b0, req_pin} < 4'(NPINS));
    is_owner = own_q[req_pin] && (owner[req_pin] == req_id);
    // The owner re-acquiring its own pin is a successful no-op.
    no_change = !req_rel && is_owner;
    grant = in_range && (req_rel ? is_owner : (!own_q[req_pin] || is_owner));

    commit_valid = (state == ARB_CHECK) && grant && !no_change;
    commit_pin   = req_pin;
    commit_code  = req_rel ? MODE_INPUT : requester_code(req_id);
  end

  assign own = own_q;

  // Request is latched in IDLE, judged and committed in CHECK (ack registered
  // so it appears together with the new mode code), then RESP drops the ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ARB_IDLE;
      req_id    <= REQ_PWM;
      req_rel   <= 1'b0;
      req_pin   <= '0;
      own_q     <= '0;
      claim_ack <= '0;
      claim_ok  <= 1'b0;
      for (int i = 0; i < MAX_PINS; i++) owner[i] <= REQ_PWM;
    end else begin
      case (state)
        ARB_IDLE: begin
          claim_ack <= '0;
          claim_ok  <= 1'b0;
          if (|claim_req) begin
            req_id  <= sel_id;
            req_rel <= claim_rel[sel_id];
            req_pin <= sel_pin;
            state   <= ARB_CHECK;
          end
        end
        ARB_CHECK: begin
          claim_ack[req_id] <= 1'b1;
          claim_ok          <= grant;
          if (commit_valid) begin
            own_q[req_pin] <= !req_rel;
            owner[req_pin] <= req_id;
          end
          state <= ARB_RESP;
        end
        ARB_RESP: begin
          claim_ack <= '0;
          claim_ok  <= 1'b0;
          state     <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/gpio_pinmux_ctrl.sv
// gpio_pinmux_ctrl: register-mapped controller for a bank of NPINS GPIO pin
// cells. Owns per-pin mode codes, software output data, interrupt edge select
// and mask, latches pin interrupts into EIFR and merges them into irq.
//   clk, rst            : clock, async active-high reset
//   bus                 : CPU register bus (slave side)
//   pin_in, pin_int     : sampled input and interrupt from each pin cell
//   output_control      : 4-bit mode code per pin
//   gpio_data, eicra, eimsk : per-pin settings driven to the pin cells
//   claim_*             : peripheral pin claim handshake (see gpio_claim_arb)
//   irq                 : registered OR of enabled pending flags
module gpio_pinmux_ctrl
  import gpio_pkg::*;
#(
  parameter int NPINS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  gpio_pinmux_ctrl_if.slave    bus,
  input  logic [NPINS-1:0]     pin_in,
  input  logic [NPINS-1:0]     pin_int,
  output logic [4*NPINS-1:0]   output_control,
  output logic [NPINS-1:0]     gpio_data,
  output logic [2*NPINS-1:0]   eicra,
  output logic [NPINS-1:0]     eimsk,
  input  logic [NUM_REQ-1:0]   claim_req,
  input  logic [NUM_REQ-1:0]   claim_rel,
  input  logic [3*NUM_REQ-1:0] claim_pin,
  output logic [NUM_REQ-1:0]   claim_ack,
  output logic                 claim_ok,
  output logic                 irq
);

  // Registers are kept at full byte width; bits for absent pins are masked
  // on every write so they always read back as 0.
  localparam logic [7:0]  PIN_MASK   = 8'((1 << NPINS) - 1);
  localparam logic [15:0] EICRA_MASK = 16'((1 << (2 * NPINS)) - 1);

  logic [7:0]          data_q;
  logic [7:0]          eimsk_q;
  logic [7:0]          eifr_q;
  logic [15:0]         eicra_q;
  logic [2:0]          msel;
  logic [3:0]          mode [MAX_PINS];

  logic [MAX_PINS-1:0] own;
  logic                commit_valid;
  logic [2:0]          commit_pin;
  logic [3:0]          commit_code;

  logic [7:0]          eifr_clr;
  logic                mode_write_ok;
  logic [7:0]          rd_mux;

  gpio_claim_arb #(.NPINS(NPINS)) u_arb (
    .clk          (clk),
    .rst          (rst),
    .claim_req    (claim_req),
    .claim_rel    (claim_rel),
    .claim_pin    (claim_pin),
    .claim_ack    (claim_ack),
    .claim_ok     (claim_ok),
    .own          (own),
    .commit_valid (commit_valid),
    .commit_pin   (commit_pin),
    .commit_code  (commit_code)
  );

  always_comb begin
    eifr_clr = (bus.bus_we && bus.bus_addr == ADDR_EIFR) ? bus.bus_wdata : 8'h00;

    // Software may only switch an unowned, existing pin between input and
    // GPIO out; a claim committing to the same pin this cycle takes priority.
    mode_write_ok = bus.bus_we && (bus.bus_addr == ADDR_MODE) &&
                    ((bus.bus_wdata[3:0] == MODE_INPUT) ||
                     (bus.bus_wdata[3:0] == MODE_GPIO_OUT)) &&
                    ({1'b0, msel} < 4'(NPINS)) && !own[msel] &&
                    !(commit_valid && (commit_pin == msel));

    case (bus.bus_addr)
      ADDR_DATA:     rd_mux = data_q;
      ADDR_PIN:      rd_mux = 8'(pin_in);
      ADDR_EIMSK:    rd_mux = eimsk_q;
      ADDR_EIFR:     rd_mux = eifr_q;
      ADDR_EICRA_LO: rd_mux = eicra_q[7:0];
      ADDR_EICRA_HI: rd_mux = eicra_q[15:8];
      ADDR_MSEL:     rd_mux = {5'b00000, msel};
      ADDR_MODE:     rd_mux = {4'b0000, mode[msel]};
      ADDR_OWN:      rd_mux = own & PIN_MASK;
      default:       rd_mux = 8'h00;
    endcase

    output_control = '0;
    for (int k = 0; k < NPINS; k++) output_control[4*k +: 4] = mode[k];
  end

  assign gpio_data = data_q[NPINS-1:0];
  assign eimsk     = eimsk_q[NPINS-1:0];
  assign eicra     = eicra_q[2*NPINS-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q         <= '0;
      eimsk_q        <= '0;
      eifr_q         <= '0;
      eicra_q        <= '0;
      msel           <= '0;
      irq            <= 1'b0;
      bus.bus_rdata  <= '0;
      bus.bus_rvalid <= 1'b0;
      for (int i = 0; i < MAX_PINS; i++) mode[i] <= MODE_INPUT;
    end else begin
      // A new interrupt pulse overrides a simultaneous write-1-to-clear.
      eifr_q <= ((eifr_q & ~eifr_clr) | 8'(pin_int)) & PIN_MASK;
      irq    <= |(eifr_q & eimsk_q);

      if (bus.bus_we) begin
        case (bus.bus_addr)
          ADDR_DATA:     data_q        <= bus.bus_wdata & PIN_MASK;
          ADDR_EIMSK:    eimsk_q       <= bus.bus_wdata & PIN_MASK;
          ADDR_EICRA_LO: eicra_q[7:0]  <= bus.bus_wdata & EICRA_MASK[7:0];
          ADDR_EICRA_HI: eicra_q[15:8] <= bus.bus_wdata & EICRA_MASK[15:8];
          ADDR_MSEL:     msel          <= bus.bus_wdata[2:0];
          default: ;
        endcase
      end

      if (mode_write_ok) mode[msel] <= bus.bus_wdata[3:0];
      if (commit_valid)  mode[commit_pin] <= commit_code;

      bus.bus_rvalid <= bus.bus_re;
      bus.bus_rdata  <= bus.bus_re ? rd_mux : 8'h00;
    end
  end

endmodule

// File: tb/tb_gpio_pinmux_ctrl.sv
// tb_gpio_pinmux_ctrl: self-checking bench for gpio_pinmux_ctrl.
// Bus vectors come from a table; read data and claim acks are checked through
// expected-result queues popped by negedge monitors.
module tb_gpio_pinmux_ctrl;

  logic        clk;
  logic        rst;
  logic [7:0]  pin_in;
  logic [7:0]  pin_int;
  logic [31:0] output_control;
  logic [7:0]  gpio_data;
  logic [15:0] eicra;
  logic [7:0]  eimsk;
  logic [3:0]  claim_req;
  logic [3:0]  claim_rel;
  logic [11:0] claim_pin;
  logic [3:0]  claim_ack;
  logic        claim_ok;
  logic        irq;

  gpio_pinmux_ctrl_if bus_if ();

  gpio_pinmux_ctrl #(.NPINS(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus_if),
    .pin_in         (pin_in),
    .pin_int        (pin_int),
    .output_control (output_control),
    .gpio_data      (gpio_data),
    .eicra          (eicra),
    .eimsk          (eimsk),
    .claim_req      (claim_req),
    .claim_rel      (claim_rel),
    .claim_pin      (claim_pin),
    .claim_ack      (claim_ack),
    .claim_ok       (claim_ok),
    .irq            (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [3:0]  addr;
    logic [7:0]  wdata;
    logic [7:0]  pins;
    logic [7:0]  exp_rd;
    logic [31:0] exp_oc;
    logic [7:0]  exp_gd;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] rd_q[$];
  logic [4:0] ack_q[$];
  vec_t       tbl[$];

  localparam logic [31:0] OC1 = 32'h0000_1000;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mkVec(input logic we, input logic [3:0] addr, input logic [7:0] wdata,
                                 input logic [7:0] pins, input logic [7:0] exp_rd,
                                 input logic [31:0] exp_oc, input logic [7:0] exp_gd);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.pins = pins;
    v.exp_rd = exp_rd; v.exp_oc = exp_oc; v.exp_gd = exp_gd;
    return v;
  endfunction

  // Called at a negedge; returns at the negedge after the active edge.
  task automatic applyStimulus(input vec_t v);
    pin_in = v.pins;
    bus_if.bus_addr = v.addr;
    bus_if.bus_wdata = v.wdata;
    if (v.we) bus_if.bus_we = 1'b1;
    else begin
      bus_if.bus_re = 1'b1;
      rd_q.push_back(v.exp_rd);
    end
    @(negedge clk);
    bus_if.bus_we = 1'b0;
    bus_if.bus_re = 1'b0;
    checkOutput($sformatf("output_control@%0h", v.addr), output_control, v.exp_oc);
    checkOutput($sformatf("gpio_data@%0h", v.addr), 32'(gpio_data), 32'(v.exp_gd));
    if (!v.we) checkOutput($sformatf("rvalid@%0h", v.addr), 32'(bus_if.bus_rvalid), 32'd1);
  endtask

  task automatic claimOp(input int id, input logic rel, input logic [2:0] pin, input logic ok_exp);
    logic [3:0] oh;
    int cyc;
    bit got;
    oh = 4'b0001 << id;
    ack_q.push_back({oh, ok_exp});
    claim_req[id] = 1'b1;
    claim_rel[id] = rel;
    claim_pin[3*id +: 3] = pin;
    got = 0;
    cyc = 0;
    while (!got && cyc < 8) begin
      @(negedge clk);
      cyc++;
      if (claim_ack[id]) got = 1;
    end
    if (!got) checkOutput("ack_timeout", 32'd0, 32'd1);
    else checkOutput($sformatf("ack_latency_r%0d", id), 32'(cyc), 32'd2);
    claim_req[id] = 1'b0;
    claim_rel[id] = 1'b0;
    @(negedge clk);
  endtask

  // Scoreboard monitors: every observed read result or claim ack must match
  // the oldest expectation queued when the stimulus was driven.
  always @(negedge clk) begin
    if (bus_if.bus_rvalid === 1'b1) begin
      if (rd_q.size() == 0) checkOutput("rd_unexpected", 32'd1, 32'd0);
      else checkOutput("rdata", 32'(bus_if.bus_rdata), 32'(rd_q.pop_front()));
    end
    if (claim_ack !== 4'b0000) begin
      if (ack_q.size() == 0) checkOutput("ack_unexpected", 32'(claim_ack), 32'd0);
      else begin
        logic [4:0] e;
        e = ack_q.pop_front();
        checkOutput("claim_ack", 32'(claim_ack), 32'(e[4:1]));
        checkOutput("claim_ok", 32'(claim_ok), 32'(e[0]));
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    pin_in = '0; pin_int = '0;
    claim_req = '0; claim_rel = '0; claim_pin = '0;
    bus_if.bus_we = 1'b0; bus_if.bus_re = 1'b0;
    bus_if.bus_addr = '0; bus_if.bus_wdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] reset state");
    checkOutput("rst_oc", output_control, 32'h0);
    checkOutput("rst_irq", 32'(irq), 32'd0);
    checkOutput("rst_ack", 32'(claim_ack), 32'd0);
    for (int a = 0; a < 16; a++) applyStimulus(mkVec(1'b0, 4'(a), 8'h00, 8'h00, 8'h00, 32'h0, 8'h00));

    $display("[TB] register table");
    tbl.push_back(mkVec(1, 4'h6, 8'h03, 8'h00, 8'h00, 32'h0, 8'h00));
    tbl.push_back(mkVec(1, 4'h7, 8'h01, 8'h00, 8'h00, OC1, 8'h00));
    tbl.push_back(mkVec(0, 4'h7, 8'h00, 8'h00, 8'h01, OC1, 8'h00));
    tbl.push_back(mkVec(1, 4'h0, 8'h08, 8'h00, 8'h00, OC1, 8'h08));
    tbl.push_back(mkVec(0, 4'h0, 8'h00, 8'h00, 8'h08, OC1, 8'h08));
    tbl.push_back(mkVec(1, 4'h7, 8'h02, 8'h00, 8'h00, OC1, 8'h08));
    tbl.push_back(mkVec(0, 4'h7, 8'h00, 8'h00, 8'h01, OC1, 8'h08));
    tbl.push_back(mkVec(1, 4'h2, 8'hA5, 8'h00, 8'h00, OC1, 8'h08));
    tbl.push_back(mkVec(0, 4'h2, 8'h00, 8'h00, 8'hA5, OC1, 8'h08));
    tbl.push_back(mkVec(1, 4'h4, 8'hC3, 8'h00, 8'h00, OC1, 8'h08));
    tbl.push_back(mkVec(0, 4'h4, 8'h00, 8'h00, 8'hC3, OC1, 8'h08));
    tbl.push_back(mkVec(1, 4'h5, 8'h3C, 8'h00, 8'h00, OC1, 8'h08));
    tbl.push_back(mkVec(0, 4'h5, 8'h00, 8'h00, 8'h3C, OC1, 8'h08));
    tbl.push_back(mkVec(0, 4'h1, 8'h00, 8'h5A, 8'h5A, OC1, 8'h08));
    tbl.push_back(mkVec(1, 4'h9, 8'hFF, 8'h00, 8'h00, OC1, 8'h08));
    tbl.push_back(mkVec(0, 4'h9, 8'h00, 8'h00, 8'h00, OC1, 8'h08));
    tbl.push_back(mkVec(1, 4'h8, 8'hFF, 8'h00, 8'h00, OC1, 8'h08));
    tbl.push_back(mkVec(0, 4'h8, 8'h00, 8'h00, 8'h00, OC1, 8'h08));
    tbl.push_back(mkVec(1, 4'h1, 8'hFF, 8'h00, 8'h00, OC1, 8'h08));
    tbl.push_back(mkVec(0, 4'h1, 8'h00, 8'h00, 8'h00, OC1, 8'h08));
    tbl.push_back(mkVec(0, 4'h3, 8'h00, 8'h00, 8'h00, OC1, 8'h08));
    tbl.push_back(mkVec(1, 4'h6, 8'h0B, 8'h00, 8'h00, OC1, 8'h08));
    tbl.push_back(mkVec(0, 4'h6, 8'h00, 8'h00, 8'h03, OC1, 8'h08));
    for (int i = 0; i < tbl.size(); i++) applyStimulus(tbl[i]);
    checkOutput("eimsk_out", 32'(eimsk), 32'h0000_00A5);
    checkOutput("eicra_out", 32'(eicra), 32'h0000_3CC3);

    $display("[TB] dual claim on pin 5");
    ack_q.push_back({4'b0100, 1'b1});
    ack_q.push_back({4'b0001, 1'b0});
    claim_req = 4'b0101;
    claim_pin[2:0] = 3'd5;
    claim_pin[8:6] = 3'd5;
    @(negedge clk);
    checkOutput("dual_ack_early", 32'(claim_ack), 32'd0);
    checkOutput("dual_oc_early", 32'(output_control[23:20]), 32'd0);
    @(negedge clk);
    checkOutput("dual_ack_utx", 32'(claim_ack), 32'b0100);
    checkOutput("dual_oc_utx", 32'(output_control[23:20]), 32'h4);
    claim_req[2] = 1'b0;
    begin
      bit got = 0;
      for (int c = 0; c < 8 && !got; c++) begin
        @(negedge clk);
        if (claim_ack[0]) got = 1;
      end
      if (!got) checkOutput("dual_pwm_timeout", 32'd0, 32'd1);
    end
    claim_req = '0;
    @(negedge clk);
    applyStimulus(mkVec(0, 4'h8, 8'h00, 8'h00, 8'h20, 32'h0040_1000, 8'h08));

    $display("[TB] release and owned-pin MODE write");
    claimOp(1, 1'b1, 3'd5, 1'b0);
    applyStimulus(mkVec(1, 4'h6, 8'h05, 8'h00, 8'h00, 32'h0040_1000, 8'h08));
    applyStimulus(mkVec(1, 4'h7, 8'h01, 8'h00, 8'h00, 32'h0040_1000, 8'h08));
    applyStimulus(mkVec(0, 4'h7, 8'h00, 8'h00, 8'h04, 32'h0040_1000, 8'h08));
    claimOp(2, 1'b1, 3'd5, 1'b1);
    checkOutput("utx_rel_oc", output_control, OC1);
    applyStimulus(mkVec(0, 4'h8, 8'h00, 8'h00, 8'h00, OC1, 8'h08));

    $display("[TB] owner re-acquire");
    claimOp(3, 1'b0, 3'd2, 1'b1);
    checkOutput("urx_oc", output_control, 32'h0000_1500);
    claimOp(3, 1'b0, 3'd2, 1'b1);
    checkOutput("urx_reacq_oc", output_control, 32'h0000_1500);
    claimOp(0, 1'b0, 3'd2, 1'b0);
    applyStimulus(mkVec(0, 4'h8, 8'h00, 8'h00, 8'h04, 32'h0000_1500, 8'h08));
    claimOp(3, 1'b1, 3'd2, 1'b1);
    checkOutput("urx_rel_oc", output_control, OC1);

    $display("[TB] claim vs MODE write on same pin");
    applyStimulus(mkVec(1, 4'h6, 8'h04, 8'h00, 8'h00, OC1, 8'h08));
    ack_q.push_back({4'b0001, 1'b1});
    claim_req[0] = 1'b1;
    claim_pin[2:0] = 3'd4;
    @(negedge clk);
    bus_if.bus_we = 1'b1;
    bus_if.bus_addr = 4'h7;
    bus_if.bus_wdata = 8'h01;
    @(negedge clk);
    bus_if.bus_we = 1'b0;
    checkOutput("race_ack", 32'(claim_ack), 32'b0001);
    checkOutput("race_oc", output_control, 32'h0002_1000);
    claim_req[0] = 1'b0;
    @(negedge clk);
    claimOp(0, 1'b1, 3'd4, 1'b1);
    applyStimulus(mkVec(0, 4'h7, 8'h00, 8'h00, 8'h00, OC1, 8'h08));

    $display("[TB] interrupts");
    applyStimulus(mkVec(1, 4'h2, 8'h01, 8'h00, 8'h00, OC1, 8'h08));
    pin_int[0] = 1'b1;
    @(negedge clk);
    pin_int[0] = 1'b0;
    checkOutput("irq_plus1", 32'(irq), 32'd0);
    @(negedge clk);
    checkOutput("irq_plus2", 32'(irq), 32'd1);
    applyStimulus(mkVec(0, 4'h3, 8'h00, 8'h00, 8'h01, OC1, 8'h08));
    pin_int[0] = 1'b1;
    applyStimulus(mkVec(1, 4'h3, 8'h01, 8'h00, 8'h00, OC1, 8'h08));
    pin_int[0] = 1'b0;
    applyStimulus(mkVec(0, 4'h3, 8'h00, 8'h00, 8'h01, OC1, 8'h08));
    checkOutput("irq_set_wins", 32'(irq), 32'd1);
    applyStimulus(mkVec(1, 4'h3, 8'h01, 8'h00, 8'h00, OC1, 8'h08));
    checkOutput("irq_clr_plus1", 32'(irq), 32'd1);
    @(negedge clk);
    checkOutput("irq_clr_plus2", 32'(irq), 32'd0);
    pin_int[1] = 1'b1;
    @(negedge clk);
    pin_int[1] = 1'b0;
    applyStimulus(mkVec(0, 4'h3, 8'h00, 8'h00, 8'h02, OC1, 8'h08));
    checkOutput("irq_masked", 32'(irq), 32'd0);

    $display("[TB] reset during CHECK");
    claim_req[0] = 1'b1;
    claim_pin[2:0] = 3'd1;
    @(negedge clk);
    rst = 1'b1;
    claim_req = '0;
    #1;
    checkOutput("rst_mid_ack", 32'(claim_ack), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid_ack2", 32'(claim_ack), 32'd0);
    checkOutput("rst_mid_oc", output_control, 32'h0);
    checkOutput("rst_mid_gd", 32'(gpio_data), 32'd0);
    checkOutput("rst_mid_eimsk", 32'(eimsk), 32'd0);
    checkOutput("rst_mid_eicra", 32'(eicra), 32'd0);
    checkOutput("rst_mid_irq", 32'(irq), 32'd0);
    applyStimulus(mkVec(0, 4'h8, 8'h00, 8'h00, 8'h00, 32'h0, 8'h00));
    applyStimulus(mkVec(0, 4'h6, 8'h00, 8'h00, 8'h00, 32'h0, 8'h00));
    applyStimulus(mkVec(0, 4'h3, 8'h00, 8'h00, 8'h00, 32'h0, 8'h00));
    claimOp(0, 1'b0, 3'd1, 1'b1);
    checkOutput("post_rst_claim_oc", output_control, 32'h0000_0020);

    repeat (3) @(negedge clk);
    checkOutput("rd_queue_drained", 32'(rd_q.size()), 32'd0);
    checkOutput("ack_queue_drained", 32'(ack_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpio_pinmux_ctrl.md
# gpio_pinmux_ctrl

Register-mapped controller for a bank of `NPINS` GPIO pin cells; it owns every per-pin `output_control`, `gpio_data`, `EICRA` and `EIMSK` setting. It arbitrates claims on pins from the on-chip peripherals: PWM, tone, UART TX and UART RX. Per-pin interrupt pulses are latched into a pending register and merged into a single `irq` for the CPU. It sits between the CPU peripheral bus and the array of pin cells.

## Interface
- `NPINS`, 8: number of pin cells; 2..8. The pin index field is 3 bits.
- `clk` input 1: clock.
- `rst` input 1: reset, asynchronous, active-high.
- `bus_we` input 1: write strobe, single cycle.
- `bus_re` input 1: read strobe, single cycle.
- `bus_addr` input 4: register address.
- `bus_wdata` input 8: write data.
- `bus_rdata` output 8: read data, registered.
- `bus_rvalid` output 1: one-cycle pulse qualifying `bus_rdata`.
- `pin_in` input NPINS: sampled `in` from each pin cell.
- `pin_int` input NPINS: `INT` from each pin cell.
- `output_control` output 4*NPINS: per-pin mode code; pin k uses bits [4k+3:4k].
- `gpio_data` output NPINS: software output values.
- `eicra` output 2*NPINS: per-pin edge/level select.
- `eimsk` output NPINS: per-pin interrupt enable.
- `claim_req` input 4: requester r asks for a pin. r is 0=PWM, 1=tone, 2=UART TX, 3=UART RX.
- `claim_rel` input 4: qualifies `claim_req[r]`. 1 = release, 0 = acquire.
- `claim_pin` input 12: pin index for requester r in bits [3r+2:3r].
- `claim_ack` output 4: one-cycle done pulse, one bit per requester.
- `claim_ok` output 1: outcome; valid only with `claim_ack`.
- `irq` output 1: combined interrupt, registered.

## Operation
- Registers:
  - 0x0 DATA (R/W) → `gpio_data`.
  - 0x1 PIN (RO) = `pin_in`.
  - 0x2 EIMSK (R/W).
  - 0x3 EIFR: pending flags, write-1-to-clear.
  - 0x4 EICRA_LO: pins 0-3. 0x5 EICRA_HI: pins 4-7.
  - 0x6 MSEL: pin index, bits [2:0].
  - 0x7 MODE (R/W): bits [3:0] hold the code of pin MSEL.
  - 0x8 OWN (RO): one bit per claimed pin.
  - Other addresses read 0; writes to them are ignored.
  - Bits ≥ NPINS read 0.
- Mode codes: 0000 input, 0001 GPIO out, 0010 PWM, 0011 tone, 0100 UART TX, 0101 UART RX.
  - Software may write MODE only with 0000 or 0001. Other values are ignored.
  - A MODE write to an owned pin is ignored.
- Claim arbiter FSM:
  - IDLE: when any `claim_req` is high, latch the highest-priority requester. Priority order is UART RX > UART TX > PWM > tone. Go to CHECK.
  - CHECK, acquire: succeeds if the pin is unowned and the index is < NPINS. On success, set the pin to the requester's code, set its OWN bit and record the owner ID.
  - CHECK, release: succeeds only if the requester is the recorded owner. On success, restore code 0000 and clear OWN.
  - Then go to RESP.
  - RESP: pulse `claim_ack[r]` with `claim_ok`, then return to IDLE.
  - A failed request leaves all state unchanged.
  - A requester holds its request until it sees its ack.
  - An acquire by the current owner of the same pin succeeds with no change.
- Interrupts:
  - EIFR[k] sets on any cycle with `pin_int[k]` = 1.
  - If a set and a W1C clear hit the same bit in the same cycle, the set wins.
  - `irq` = OR over (EIFR & EIMSK), registered.
- Reset values: every `output_control` = 0000, all other outputs 0, OWN = 0, MSEL = 0, FSM in IDLE.

## Timing
- A write is visible on the outputs in the cycle after `bus_we`.
- A read returns `bus_rdata` and `bus_rvalid` in the cycle after `bus_re`.
- Claim: request seen in IDLE at cycle N. CHECK runs at N+1. `output_control` updates and `claim_ack` pulses at N+2. Earliest next acceptance is N+3.
- If a claim commits in the same cycle as a bus MODE write to the same pin, the claim wins.
- `irq` rises 2 cycles after `pin_int` (EIFR, then the `irq` register). It falls 2 cycles after the W1C write.
- Asserting `rst` mid-claim aborts it: no ack and no ownership.

## Structure
- Package `gpio_pkg`: mode-code constants, register address constants, requester ID constants and priority order, FSM state encoding.
- Sub-module `gpio_claim_arb`: the priority select and IDLE/CHECK/RESP FSM plus the owner table. It outputs a one-cycle commit (pin, code, set/clear).
- Top level: register file, EIFR logic, read mux.

## Test plan
- Reset, then read all addresses → 0, `output_control` = 0x00000000, `irq` = 0.
- MSEL = 3, MODE = 0001, DATA = 0x08 → `output_control[15:12]` = 0001 and `gpio_data[3]` = 1 one cycle after each write. MODE = 0010 → ignored.
- PWM and UART TX both request pin 5 in the same cycle → UART TX acked with ok = 1 at +2, code = 0100. PWM is then acked with ok = 0. OWN = 0x20.
- Tone releases pin 5 → ok = 0. UART TX releases pin 5 → ok = 1, code 0000, OWN = 0. A MODE write to pin 5 while it is owned → no change.
- EIMSK = 0x01, `pin_int[0]` pulsed → EIFR = 0x01, `irq` = 1 at +2. Write EIFR = 0x01 in the same cycle as a new pulse → EIFR stays 1.
- Assert `rst` during CHECK → no `claim_ack`, OWN = 0, all outputs return to their reset values.
